// File: rtl/fft_ctrl_pkg.sv
// rtl/fft_ctrl_pkg.sv - shared types and constants for the FFT frame sequencer
// Contents: sequencer state enum, FFT framing constants, 16-lane I/Q beat type.
package fft_ctrl_pkg;

  localparam int FFT_LANES = 16;
  localparam int FFT_BEATS = 32;
  localparam int FFT_DW    = 9;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAD,
    GAP
  } seq_state_t;

  typedef logic signed [FFT_DW-1:0] fft_sample_t;

  typedef struct packed {
    fft_sample_t [FFT_LANES-1:0] i;
    fft_sample_t [FFT_LANES-1:0] q;
  } fft_beat_t;

endpackage

// File: rtl/fft_inflight_tracker.sv
// rtl/fft_inflight_tracker.sv - frames-in-flight counter with completion counting and watchdog
// Ports:
//   clk, rstn    clock, synchronous active-low reset
//   launch       a new frame enters the pipeline this cycle
//   valid_mod1   cbfp0 output valid; OUT_BEATS high cycles complete one frame
//   inflight     launched-but-uncompleted frame count
//   wd_fire      one-cycle pulse when the stall watchdog expires
module fft_inflight_tracker
  import fft_ctrl_pkg::*;
#(
  parameter int MAX_INFLIGHT = 2,
  parameter int OUT_BEATS    = FFT_BEATS,
  parameter int WDOG_CYCLES  = 1024
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              launch,
  input  logic                              valid_mod1,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic                              wd_fire
);

  localparam int OW = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;
  localparam int WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [OW-1:0] OUT_LAST = OW'(OUT_BEATS - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(WDOG_CYCLES - 1);

  logic [OW-1:0] out_cnt;
  logic [WW-1:0] wd_cnt;
  logic          stall;
  logic          complete;
  logic          dec;

  assign stall    = (inflight != '0) && !valid_mod1;
  assign wd_fire  = stall && (wd_cnt == WD_LAST);
  assign complete = valid_mod1 && (out_cnt == OUT_LAST);
  // A completion with nothing in flight is a stray burst; it only resets out_cnt.
  assign dec      = complete && (inflight != '0);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      inflight <= '0;
      out_cnt  <= '0;
      wd_cnt   <= '0;
    end else if (wd_fire) begin
      // Watchdog abandons everything in flight, including a same-cycle launch.
      inflight <= '0;
      out_cnt  <= '0;
      wd_cnt   <= '0;
    end else begin
      wd_cnt <= stall ? wd_cnt + 1'b1 : '0;
      if (valid_mod1) out_cnt <= complete ? '0 : out_cnt + 1'b1;
      if (launch && !dec)      inflight <= inflight + 1'b1;
      else if (!launch && dec) inflight <= inflight - 1'b1;
    end
  end

endmodule

// File: rtl/fft_frame_sequencer.sv
// rtl/fft_frame_sequencer.sv - frame launcher and flow controller feeding the 512-point FFT
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   enable                    permits new frame launches
//   clr_err                   pulse clearing sticky errors
//   s_valid/s_ready/s_din_*   source beat handshake and 16 I/Q lanes
//   m_valid/m_din_*           registered beat stream to mod0_0
//   valid_mod1                cbfp0 output valid
//   inflight, frames_launched frame accounting
//   busy, err_underrun, err_timeout  status
module fft_frame_sequencer
  import fft_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH      = 9,
  parameter int NUM_LANES       = FFT_LANES,
  parameter int BEATS_PER_FRAME = FFT_BEATS,
  parameter int OUT_BEATS       = FFT_BEATS,
  parameter int MAX_INFLIGHT    = 2,
  parameter int MIN_GAP         = 0,
  parameter int WDOG_CYCLES     = 1024
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              enable,
  input  logic                              clr_err,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic signed [DATA_WIDTH-1:0]      s_din_i [0:NUM_LANES-1],
  input  logic signed [DATA_WIDTH-1:0]      s_din_q [0:NUM_LANES-1],
  output logic                              m_valid,
  output logic signed [DATA_WIDTH-1:0]      m_din_i [0:NUM_LANES-1],
  output logic signed [DATA_WIDTH-1:0]      m_din_q [0:NUM_LANES-1],
  input  logic                              valid_mod1,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic [15:0]                       frames_launched,
  output logic                              busy,
  output logic                              err_underrun,
  output logic                              err_timeout
);

  localparam int BW = (BEATS_PER_FRAME > 1) ? $clog2(BEATS_PER_FRAME) : 1;
  localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS_PER_FRAME - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);
  localparam seq_state_t    END_ST    = (MIN_GAP > 0) ? GAP : IDLE;

  seq_state_t    state;
  logic [BW-1:0] beat_cnt;
  logic [GW-1:0] gap_cnt;
  logic          launch;
  logic          underrun;
  logic          wd_fire;

  always_comb begin
    s_ready = 1'b0;
    case (state)
      IDLE:    s_ready = enable && (int'(inflight) < MAX_INFLIGHT);
      RUN:     s_ready = 1'b1;
      default: s_ready = 1'b0;
    endcase
  end

  assign launch   = (state == IDLE) && s_valid && s_ready;
  assign underrun = (state == RUN) && !s_valid;
  assign busy     = (state != IDLE) || (inflight != '0);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state           <= IDLE;
      beat_cnt        <= '0;
      gap_cnt         <= '0;
      m_valid         <= 1'b0;
      frames_launched <= '0;
      err_underrun    <= 1'b0;
      err_timeout     <= 1'b0;
      for (int l = 0; l < NUM_LANES; l++) begin
        m_din_i[l] <= '0;
        m_din_q[l] <= '0;
      end
    end else begin
      // A same-cycle set beats clr_err.
      err_underrun <= underrun | (err_underrun & ~clr_err);
      err_timeout  <= wd_fire | (err_timeout & ~clr_err);
      case (state)
        IDLE: begin
          m_valid <= launch;
          for (int l = 0; l < NUM_LANES; l++) begin
            m_din_i[l] <= launch ? s_din_i[l] : '0;
            m_din_q[l] <= launch ? s_din_q[l] : '0;
          end
          if (launch) begin
            state           <= RUN;
            beat_cnt        <= BW'(1);
            frames_launched <= frames_launched + 16'd1;
          end
        end
        RUN, PAD: begin
          // Every cycle of a frame emits a beat; missing source data becomes zeros.
          m_valid <= 1'b1;
          for (int l = 0; l < NUM_LANES; l++) begin
            m_din_i[l] <= (state == RUN && s_valid) ? s_din_i[l] : '0;
            m_din_q[l] <= (state == RUN && s_valid) ? s_din_q[l] : '0;
          end
          if (underrun) state <= PAD;
          if (beat_cnt == BEAT_LAST) begin
            beat_cnt <= '0;
            state    <= END_ST;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        GAP: begin
          m_valid <= 1'b0;
          for (int l = 0; l < NUM_LANES; l++) begin
            m_din_i[l] <= '0;
            m_din_q[l] <= '0;
          end
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  fft_inflight_tracker #(
    .MAX_INFLIGHT (MAX_INFLIGHT),
    .OUT_BEATS    (OUT_BEATS),
    .WDOG_CYCLES  (WDOG_CYCLES)
  ) u_tracker (
    .clk        (clk),
    .rstn       (rstn),
    .launch     (launch),
    .valid_mod1 (valid_mod1),
    .inflight   (inflight),
    .wd_fire    (wd_fire)
  );

endmodule
